// File: rtl/syndrome_frame_sequencer_pkg.sv
// Shared constants, state encodings and frame-size helpers for the Helios host sequencer.
package syndrome_frame_sequencer_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef logic [2:0] state_t;
  localparam state_t ST_START  = 3'd0;
  localparam state_t ST_ARM    = 3'd1;
  localparam state_t ST_HDR    = 3'd2;
  localparam state_t ST_MEAS   = 3'd3;
  localparam state_t ST_RHDR   = 3'd4;
  localparam state_t ST_RCORR  = 3'd5;
  localparam state_t ST_REPORT = 3'd6;
  localparam state_t ST_HALT   = 3'd7;

  function automatic int phys_u(input int u, input int nc);
    return (u + nc - 1) / nc;
  endfunction

  function automatic int meas_bytes(input int x, input int z, input int u, input int nc);
    return ((x * z + 7) / 8) * phys_u(u, nc) * nc;
  endfunction

  // Correction bitmap: two edge families of (X-1)*Z, one boundary bit, X*Z vertical edges.
  function automatic int corr_bytes(input int x, input int z, input int u, input int nc);
    int cnt;
    cnt = 2 * (x - 1) * z + 1 + x * z;
    return ((cnt + 7) / 8) * phys_u(u, nc) * nc;
  endfunction

endpackage

// File: rtl/syndrome_frame_sequencer_frame_byte_counter.sv
// Byte position counter with synchronous clear, increment and terminal-count flag.
module frame_byte_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_last
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_count <= '0;
    else if (i_inc)     r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_last  = (r_count == i_term);
endmodule

// File: rtl/syndrome_frame_sequencer.sv
// Host-side sequencer: frames measurement payloads into a Helios decoder and parses its results.
module syndrome_frame_sequencer
  import syndrome_frame_sequencer_pkg::*;
#(
  parameter int GRID_WIDTH_X   = 6,
  parameter int GRID_WIDTH_Z   = 2,
  parameter int GRID_WIDTH_U   = 5,
  parameter int NUM_CONTEXTS   = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  meas_data,
  input  logic        meas_valid,
  output logic        meas_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  corr_data,
  output logic        corr_valid,
  input  logic        corr_ready,
  output logic [15:0] corr_index,
  output logic        res_valid,
  output logic [7:0]  res_iterations,
  output logic [15:0] res_cycles,
  output logic [31:0] tests_done,
  output logic        busy,
  output logic        timeout_err
);
  localparam int MEAS_BYTES = meas_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U, NUM_CONTEXTS);
  localparam int CORR_BYTES = corr_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U, NUM_CONTEXTS);
  localparam logic [15:0] MEAS_TERM = 16'(MEAS_BYTES - 1);
  localparam logic [15:0] CORR_TERM = 16'(CORR_BYTES - 1);
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      r_state;
  logic [7:0]  r_iter, r_res_iter;
  logic [15:0] r_cyc, r_res_cyc;
  logic [31:0] r_tests, r_idle;
  logic        r_terr;

  logic [7:0]  w_tx_data, w_corr_data;
  logic        w_tx_valid, w_meas_ready, w_rx_ready, w_corr_valid;
  logic [15:0] w_corr_index, w_rx_cnt, w_tx_cnt_unused, w_rx_term;
  logic        w_tx_xfer, w_rx_xfer, w_tx_last, w_rx_last, w_in_rx, w_timeout;

  always_comb begin
    w_tx_data    = '0;
    w_tx_valid   = 1'b0;
    w_meas_ready = 1'b0;
    w_rx_ready   = 1'b0;
    w_corr_valid = 1'b0;
    w_corr_data  = '0;
    w_corr_index = '0;
    case (r_state)
      ST_START: begin w_tx_data = START_DECODING_MSG;      w_tx_valid = 1'b1; end
      ST_HDR:   begin w_tx_data = MEASUREMENT_DATA_HEADER; w_tx_valid = 1'b1; end
      ST_MEAS: begin
        w_tx_data    = meas_data;
        w_tx_valid   = meas_valid;
        w_meas_ready = tx_ready;
      end
      ST_RHDR: w_rx_ready = 1'b1;
      ST_RCORR: begin
        w_rx_ready   = corr_ready;
        w_corr_valid = rx_valid;
        w_corr_data  = rx_data;
        w_corr_index = w_rx_cnt;
      end
      default: ;
    endcase
    // State decodes to START during reset; keep every handshake quiet until it is released.
    if (reset) begin
      w_tx_data    = '0;
      w_tx_valid   = 1'b0;
      w_meas_ready = 1'b0;
      w_rx_ready   = 1'b0;
      w_corr_valid = 1'b0;
      w_corr_data  = '0;
      w_corr_index = '0;
    end
  end

  assign w_tx_xfer = w_tx_valid && tx_ready;
  assign w_rx_xfer = w_rx_ready && rx_valid;
  assign w_in_rx   = (r_state == ST_RHDR) || (r_state == ST_RCORR);
  assign w_rx_term = (r_state == ST_RHDR) ? 16'd2 : CORR_TERM;
  // A byte landing on the expiry cycle counts as progress.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_in_rx && !w_rx_xfer && (r_idle == IDLE_LAST);

  frame_byte_counter #(.W(16)) u_tx_cnt (
    .clk(clk), .reset(reset),
    .i_clr((r_state == ST_HDR) && w_tx_xfer),
    .i_inc((r_state == ST_MEAS) && w_tx_xfer),
    .i_term(MEAS_TERM),
    .o_count(w_tx_cnt_unused), .o_last(w_tx_last)
  );

  frame_byte_counter #(.W(16)) u_rx_cnt (
    .clk(clk), .reset(reset),
    .i_clr(((r_state == ST_MEAS) && w_tx_xfer && w_tx_last) ||
           ((r_state == ST_RHDR) && w_rx_xfer && w_rx_last)),
    .i_inc(w_rx_xfer),
    .i_term(w_rx_term),
    .o_count(w_rx_cnt), .o_last(w_rx_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_START;
      r_iter     <= '0;
      r_cyc      <= '0;
      r_res_iter <= '0;
      r_res_cyc  <= '0;
      r_tests    <= '0;
      r_idle     <= '0;
      r_terr     <= 1'b0;
    end else begin
      r_idle <= (w_in_rx && !w_rx_xfer) ? r_idle + 32'd1 : 32'd0;
      case (r_state)
        ST_START: if (w_tx_xfer) r_state <= ST_ARM;
        ST_ARM:   if (meas_valid) r_state <= ST_HDR;
        ST_HDR:   if (w_tx_xfer) r_state <= ST_MEAS;
        ST_MEAS:  if (w_tx_xfer && w_tx_last) r_state <= ST_RHDR;
        ST_RHDR: if (w_rx_xfer) begin
          case (w_rx_cnt[1:0])
            2'd0:    r_iter       <= rx_data;
            2'd1:    r_cyc[15:8]  <= rx_data;
            default: r_cyc[7:0]   <= rx_data;
          endcase
          if (w_rx_last) begin
            if (CORR_BYTES == 0) begin
              r_state    <= ST_REPORT;
              r_res_iter <= r_iter;
              r_res_cyc  <= {r_cyc[15:8], rx_data};
            end else begin
              r_state <= ST_RCORR;
            end
          end
        end
        ST_RCORR: if (w_rx_xfer && w_rx_last) begin
          r_state    <= ST_REPORT;
          r_res_iter <= r_iter;
          r_res_cyc  <= r_cyc;
        end
        ST_REPORT: begin
          r_tests <= r_tests + 32'd1;
          r_state <= ST_ARM;
        end
        ST_HALT: ;
        default: r_state <= ST_START;
      endcase
      if (w_timeout) begin
        r_state <= ST_HALT;
        r_terr  <= 1'b1;
      end
    end
  end

  assign meas_ready     = w_meas_ready;
  assign tx_data        = w_tx_data;
  assign tx_valid       = w_tx_valid;
  assign rx_ready       = w_rx_ready;
  assign corr_data      = w_corr_data;
  assign corr_valid     = w_corr_valid;
  assign corr_index     = w_corr_index;
  assign res_valid      = (r_state == ST_REPORT) && !reset;
  assign res_iterations = r_res_iter;
  assign res_cycles     = r_res_cyc;
  assign tests_done     = r_tests;
  assign busy           = (r_state != ST_ARM);
  assign timeout_err    = r_terr;
endmodule
